// File: rtl/e_pipe_reg_pkg.sv
// Shared CPU constants: MDU opcodes, exception codes and the fixed PC vectors
// used by the D->E pipeline register.
package e_pipe_reg_pkg;

    localparam logic [31:0] CPU_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] CPU_HANDLER_PC = 32'h0000_4180;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    // A cleared E stage carries no pending exception; the zero code doubles as "none".
    localparam logic [4:0] EXC_CLEAR   = EXC_INT;

endpackage

// File: rtl/e_pipe_reg_sat_counter.sv
// Width-parameterised saturating up-counter with synchronous active-low reset;
// holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r = {WIDTH{1'b0}};

    // Count enabled events, sticking at the maximum value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (inc && (count_r != {WIDTH{1'b1}})) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/e_pipe_reg.sv
// D->E pipeline register: loads the D stage, inserts bubbles on stall (keeping
// PC/BD for CP0), flushes to the handler on Req, and counts inserted bubbles.
module e_pipe_reg
    import e_pipe_reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = CPU_RESET_PC,
    parameter logic [31:0] HANDLER_PC = CPU_HANDLER_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        stall,
    input  logic [31:0] D_PC,
    input  logic [31:0] D_Instr,
    input  logic [31:0] D_RD1,
    input  logic [31:0] D_RD2,
    input  logic [31:0] D_EXT,
    input  logic [3:0]  D_MDUOp,
    input  logic [4:0]  D_ExcCode,
    input  logic        D_BD,
    output logic [31:0] E_PC,
    output logic [31:0] E_Instr,
    output logic [31:0] E_RD1,
    output logic [31:0] E_RD2,
    output logic [31:0] E_EXT,
    output logic [3:0]  E_MDUOp,
    output logic [4:0]  E_ExcCode,
    output logic        E_BD,
    output logic        E_valid,
    output logic [7:0]  bubble_cnt
);

    logic [31:0] pc_r      = RESET_PC;
    logic [31:0] instr_r   = 32'h0000_0000;
    logic [31:0] rd1_r     = 32'h0000_0000;
    logic [31:0] rd2_r     = 32'h0000_0000;
    logic [31:0] ext_r     = 32'h0000_0000;
    logic [3:0]  mdu_op_r  = MDU_NONE;
    logic [4:0]  exc_code_r = EXC_CLEAR;
    logic        bd_r      = 1'b0;
    logic        valid_r   = 1'b0;
    logic        bubble_s;

    // A bubble is counted only when the stall wins the priority race.
    assign bubble_s = reset && !Req && stall;

    // One action per edge: reset > flush > bubble > load. Clearing the MDU op
    // on a bubble keeps a stalled mult/div from starting the MDU twice.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_r       <= RESET_PC;
            instr_r    <= 32'h0000_0000;
            rd1_r      <= 32'h0000_0000;
            rd2_r      <= 32'h0000_0000;
            ext_r      <= 32'h0000_0000;
            mdu_op_r   <= MDU_NONE;
            exc_code_r <= EXC_CLEAR;
            bd_r       <= 1'b0;
            valid_r    <= 1'b0;
        end else if (Req) begin
            pc_r       <= HANDLER_PC;
            instr_r    <= 32'h0000_0000;
            rd1_r      <= 32'h0000_0000;
            rd2_r      <= 32'h0000_0000;
            ext_r      <= 32'h0000_0000;
            mdu_op_r   <= MDU_NONE;
            exc_code_r <= EXC_CLEAR;
            bd_r       <= 1'b0;
            valid_r    <= 1'b0;
        end else if (stall) begin
            pc_r       <= D_PC;
            instr_r    <= 32'h0000_0000;
            rd1_r      <= 32'h0000_0000;
            rd2_r      <= 32'h0000_0000;
            ext_r      <= 32'h0000_0000;
            mdu_op_r   <= MDU_NONE;
            exc_code_r <= EXC_CLEAR;
            bd_r       <= D_BD;
            valid_r    <= 1'b0;
        end else begin
            pc_r       <= D_PC;
            instr_r    <= D_Instr;
            rd1_r      <= D_RD1;
            rd2_r      <= D_RD2;
            ext_r      <= D_EXT;
            mdu_op_r   <= D_MDUOp;
            exc_code_r <= D_ExcCode;
            bd_r       <= D_BD;
            valid_r    <= 1'b1;
        end
    end

    sat_counter #(
        .WIDTH (8)
    ) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bubble_s),
        .count (bubble_cnt)
    );

    assign E_PC      = pc_r;
    assign E_Instr   = instr_r;
    assign E_RD1     = rd1_r;
    assign E_RD2     = rd2_r;
    assign E_EXT     = ext_r;
    assign E_MDUOp   = mdu_op_r;
    assign E_ExcCode = exc_code_r;
    assign E_BD      = bd_r;
    assign E_valid   = valid_r;

endmodule

// File: doc/e_pipe_reg.md
E_PIPE_REG -- requirements
Module: e_pipe_reg

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, value of E_PC after reset.
REQ-002 SHALL have parameter HANDLER_PC, default 32'h0000_4180, value of E_PC after an exception flush.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port Req  in  1  exception/interrupt flush request from CP0.
REQ-006 SHALL have port stall  in  1  hazard-unit stall, including MDU busy/start conflicts; 1 = insert bubble into E.
REQ-007 SHALL have ports D_PC, D_Instr, D_RD1, D_RD2, D_EXT  in  32 each  D-stage PC, instruction, forwarded operands, extended immediate.
REQ-008 SHALL have ports D_MDUOp  in  4  and D_ExcCode  in  5  and D_BD  in  1  MDU opcode (0 = none), pending exception code, branch-delay flag.
REQ-009 SHALL have ports E_PC, E_Instr, E_RD1, E_RD2, E_EXT  out  32, E_MDUOp  out  4, E_ExcCode  out  5, E_BD  out  1, all registered.
REQ-010 SHALL have port E_valid  out  1  registered; 1 = E holds a real instruction, 0 = bubble.
REQ-011 SHALL have port bubble_cnt  out  8  registered; saturating count of bubbles inserted since reset.

Function
REQ-012 SHALL apply exactly one action per rising edge, priority reset > Req > stall > load.
REQ-013 On load, SHALL copy every D_* input to the matching E_* output and set E_valid=1; latency is one cycle.
REQ-014 On Req, SHALL clear E_Instr, E_RD1, E_RD2, E_EXT, E_MDUOp, E_ExcCode, E_BD and E_valid, and set E_PC=HANDLER_PC.
REQ-015 On stall without Req, SHALL clear E_Instr, E_RD1, E_RD2, E_EXT, E_MDUOp, E_ExcCode and E_valid, but load E_PC=D_PC and E_BD=D_BD, so a bubble carries the correct victim PC and BD for CP0.
REQ-016 SHALL never hold E_MDUOp nonzero for two consecutive cycles from the same D instruction, so a stalled mult/div cannot start the MDU twice.
REQ-017 SHALL increment bubble_cnt by 1 on each stall cycle without Req, saturating at 8'hFF with no wrap.
REQ-018 SHALL leave bubble_cnt unchanged on Req.
REQ-019 When stall and Req are both 1, SHALL perform only the Req action (REQ-014), with bubble_cnt unchanged.
REQ-020 Reset asserted mid-stall or mid-flush SHALL take effect on that edge; no action is queued or carried over.
REQ-021 SHALL contain no combinational path from any input to any output.

Reset
REQ-022 On reset=0 at a rising edge, SHALL set E_PC=RESET_PC and E_Instr, E_RD1, E_RD2, E_EXT, E_MDUOp, E_ExcCode, E_BD, E_valid and bubble_cnt all to 0.
REQ-023 SHALL also apply the REQ-022 values as simulation initial values.

Structure
REQ-024 SHALL take MDUOp encodings (0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo), ExcCode encodings, RESET_PC and HANDLER_PC from the shared CPU constants package.
REQ-025 SHALL use one sub-module, sat_counter (width-parameterised, saturating), to implement bubble_cnt; all other logic SHALL be flat.

Verification
REQ-026 Scenario: reset=0 for 1 cycle -> E_PC=32'h0000_3000, E_valid=0, bubble_cnt=0.
REQ-027 Scenario: load D_PC=32'h0000_3004, D_MDUOp=1, D_RD1=7, D_RD2=6 -> next cycle E_MDUOp=1, E_RD1=7, E_RD2=6, E_valid=1.
REQ-028 Scenario: with the REQ-027 instruction in D, hold stall=1 for 3 cycles -> E_MDUOp=0 and E_valid=0 for all 3 cycles, E_PC=32'h0000_3004, bubble_cnt=3.
REQ-029 Scenario: stall=1 and Req=1 together, D_BD=1 -> E_PC=32'h0000_4180, E_BD=0, bubble_cnt unchanged.
REQ-030 Scenario: stall=1 for 300 cycles -> bubble_cnt reaches 8'hFF and stays there.
REQ-031 Scenario: reset=0 asserted during a stall run -> every output returns to its REQ-022 value on that edge.
